branch_unit: RTL

- Downstream consumer of the compare-flag stage: takes the registered Z/O/C/S flags and resolves conditional and unconditional jumps for the jrb8 core.
- Owns the 16-bit program counter (PC).
- Fetches a two-byte jump target from the 8-bit data bus, high byte first, advancing the PC over each operand byte.
- Loads the target into the PC when the condition holds; otherwise execution falls through past the operands.

---
 rtl/jrb8_pkg.sv | 28 ++
 rtl/cond_eval.sv | 36 +++
 rtl/branch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/jrb8_pkg.sv
// rtl/jrb8_pkg.sv - shared jrb8 condition codes, branch states and width defaults
package jrb8_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_NC     = 4'd4;
  localparam logic [3:0] COND_S      = 4'd5;
  localparam logic [3:0] COND_NS     = 4'd6;
  localparam logic [3:0] COND_O      = 4'd7;
  localparam logic [3:0] COND_NO     = 4'd8;
  localparam logic [3:0] COND_SLT    = 4'd9;
  localparam logic [3:0] COND_SGE    = 4'd10;
  localparam logic [3:0] COND_SGT    = 4'd11;
  localparam logic [3:0] COND_SLE    = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_HI  = 2'd1,
    ST_GET_LO  = 2'd2,
    ST_RESOLVE = 2'd3
  } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator over Z/O/C/S flags
module cond_eval
  import jrb8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       zflag,
  input  logic       oflag,
  input  logic       cflag,
  input  logic       sflag,
  output logic       take
);

  logic lt;

  always_comb begin
    lt   = sflag ^ oflag;
    take = 1'b0;
    case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_Z:      take = zflag;
      COND_NZ:     take = ~zflag;
      COND_C:      take = cflag;
      COND_NC:     take = ~cflag;
      COND_S:      take = sflag;
      COND_NS:     take = ~sflag;
      COND_O:      take = oflag;
      COND_NO:     take = ~oflag;
      COND_SLT:    take = lt;
      COND_SGE:    take = ~lt;
      COND_SGT:    take = ~zflag & ~lt;
      COND_SLE:    take = zflag | lt;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - jrb8 program counter with two-byte conditional jump sequencer
module branch_unit
  import jrb8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] databus,
  input  logic              byte_valid,
  input  logic              pc_inc,
  input  logic              jmp_start,
  input  logic [3:0]        cond,
  input  logic              zflag,
  input  logic              oflag,
  input  logic              cflag,
  input  logic              sflag,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              taken,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  br_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        cond_q, cond_d;
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              taken_q, taken_d;
  logic              done_q, done_d;
  logic              take;

  // Flags are snapshotted at jmp_start so later compares cannot alter a jump in flight.
  cond_eval u_cond_eval (
    .cond  (cond_q),
    .zflag (flags_q[3]),
    .oflag (flags_q[2]),
    .cflag (flags_q[1]),
    .sflag (flags_q[0]),
    .take  (take)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cond_d  = cond_q;
    flags_d = flags_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    taken_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jmp_start) begin
          cond_d  = cond;
          flags_d = {zflag, oflag, cflag, sflag};
          state_d = ST_GET_HI;
        end else if (pc_inc) begin
          pc_d = pc_q + PC_ONE;
        end
      end
      ST_GET_HI: begin
        if (byte_valid) begin
          hi_d    = databus;
          pc_d    = pc_q + PC_ONE;
          state_d = ST_GET_LO;
        end
      end
      ST_GET_LO: begin
        if (byte_valid) begin
          lo_d    = databus;
          pc_d    = pc_q + PC_ONE;
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (take) begin
          pc_d    = {hi_q, lo_q};
          taken_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cond_q  <= '0;
      flags_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  assign pc    = pc_q;
  assign busy  = (state_q != ST_IDLE);
  assign taken = taken_q;
  assign done  = done_q;

endmodule
